right_shifter_unit: RTL and testbench
=====================================

Name: right_shifter_unit

Overview:
- Registered 32-bit right barrel shifter for the integer ALU.
- Supports logical shift right (SRL) and arithmetic shift right (SRA).
- Shift amount is 0..WIDTH-1.
- Result and valid flag are registered one clock after the operands are accepted; the ALU result mux consumes them directly.

Parameters:
- WIDTH, 32, data width of operand and result; must be a power of two.
- SHAMT_W, 5, shift-amount width; always equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle; capture on this clk edge.
- a  input  WIDTH  operand to be shifted.
- shamt  input  SHAMT_W  shift amount, unsigned 0..WIDTH-1.
- sra  input  1  0 = logical (zero fill); 1 = arithmetic (fill with a[WIDTH-1]).
- out_valid  output  1  shifted holds a new result.
- shifted  output  WIDTH  registered shift result.

Behaviour:
- Reset: on rst_n low, shifted and out_valid clear to 0 immediately, independent of clk. They stay 0 until the first rising clk edge after rst_n goes high.
- Combinational core:
  - fill = sra & a[WIDTH-1].
  - Logical result = a >> shamt.
  - Arithmetic result = a >>> shamt, i.e. the top shamt bits equal fill.
- Core structure: log2(WIDTH) cascaded stages. Stage k shifts right by 2^k when shamt[k]=1, else passes its input through; vacated bits take fill.
- Latency: exactly 1 cycle.
  - If in_valid=1 at rising edge N, the result for a/shamt/sra sampled at edge N is on shifted after edge N.
  - out_valid=1 in the same cycle as that result.
- in_valid=0 at an edge: out_valid goes 0, shifted holds its previous value.
- No backpressure; one operation accepted per cycle. Back-to-back valid inputs produce back-to-back results.
- Boundary cases:
  - shamt=0: shifted=a for both modes.
  - shamt=WIDTH-1, logical: result = {0..., a[WIDTH-1]}.
  - shamt=WIDTH-1, arithmetic: result is all copies of a[WIDTH-1].
  - sra=1 with a[WIDTH-1]=0: result is identical to the logical shift.
- Reset asserted mid-operation discards the in-flight result. out_valid=0 after reset is released until a new in_valid is captured.
- No X propagation from an unused path: every bit of shifted is driven from the stage chain.

Decomposition:
- Shared ALU package holds:
  - constants XLEN_SHIFT=32 and SHAMT_W=5;
  - encoding SHIFT_SRL=1'b0, SHIFT_SRA=1'b1 used by the ALU decoder.
- One sub-module, right_shift_stage. It is a purely combinational single stage with parameters WIDTH and DIST, inputs (din, en, fill) and output dout.
- right_shifter_unit instantiates SHAMT_W copies of right_shift_stage, plus the output/valid register.

Test Plan:
- Logical sweep: sra=0, a=32'h80000000, shamt=0..31, in_valid=1 each cycle -> shifted = 32'h80000000>>shamt one cycle later, e.g. shamt=31 -> 32'h00000001; out_valid=1 throughout.
- Arithmetic sweep: sra=1, a=32'h80000000, shamt=0..31 -> sign-filled result, e.g. shamt=1 -> 32'hC0000000, shamt=31 -> 32'hFFFFFFFF.
- Positive SRA: sra=1, a=32'h7FFFFFFF, shamt=4 -> 32'h07FFFFFF, identical to sra=0. Also a=32'hDEADBEEF, shamt=0 -> 32'hDEADBEEF in both modes.
- Hold: valid op a=32'hF0000000, sra=1, shamt=4 -> 32'hFF000000; next cycle in_valid=0 with different a -> out_valid=0, shifted stays 32'hFF000000.
- Async reset: assert rst_n=0 between clock edges while a result is registered -> shifted=0 and out_valid=0 immediately. After release with in_valid=0 they remain 0; the first valid op then yields the correct result one cycle later.
- Random: 1000 random (a, shamt, sra) back-to-back -> each result matches the software model ((sra ? $signed(a)>>>shamt : a>>shamt)) exactly one cycle later; bench counts and reports errors, expects 0.

Source files
------------

// File: rtl/right_shifter_unit_pkg.sv
// Shared ALU shift constants and the shift-operation encoding used by the
// ALU decoder and the right shifter.
package right_shifter_unit_pkg;

   localparam int unsigned XLEN_SHIFT = 32;
   localparam int unsigned SHAMT_W    = 5;

   typedef enum logic {
      SHIFT_SRL = 1'b0,
      SHIFT_SRA = 1'b1
   } shift_op_e;

endpackage : right_shifter_unit_pkg

// File: rtl/right_shift_stage.sv
// One combinational stage of the right barrel shifter: shifts din right by
// DIST when en is set, filling the vacated top bits with fill.
module right_shift_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             fill,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      if (en) begin
         dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
      end
   end

endmodule : right_shift_stage

// File: rtl/right_shifter_unit.sv
// Registered logical/arithmetic right barrel shifter for the integer ALU.
// Result and valid flag appear one clock after the operands are captured.
module right_shifter_unit
   import right_shifter_unit_pkg::*;
#(
   parameter int unsigned WIDTH   = right_shifter_unit_pkg::XLEN_SHIFT,
   parameter int unsigned SHAMT_W = right_shifter_unit_pkg::SHAMT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               sra,
   output logic               out_valid,
   output logic [WIDTH-1:0]   shifted
);

   if (WIDTH != (1 << SHAMT_W)) begin : g_bad_params
      $error("right_shifter_unit: WIDTH must equal 2**SHAMT_W");
   end

   shift_op_e        op;
   logic             fill;
   logic [WIDTH-1:0] stage_data [SHAMT_W+1];

   always_comb begin
      op   = sra ? SHIFT_SRA : SHIFT_SRL;
      fill = (op == SHIFT_SRA) & a[WIDTH-1];
   end

   assign stage_data[0] = a;

   // Stage k shifts by 2^k under shamt[k]; the last stage output is the result.
   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      right_shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_stage (
         .din  (stage_data[k]),
         .en   (shamt[k]),
         .fill (fill),
         .dout (stage_data[k+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shifted   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            shifted <= stage_data[SHAMT_W];
         end
      end
   end

endmodule : right_shifter_unit

// File: tb/tb_right_shifter_unit.sv
// Scoreboard bench for right_shifter_unit: expected results are queued when
// operands are driven and popped when the registered result appears.
module tb_right_shifter_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic        sra;
   logic        out_valid;
   logic [31:0] shifted;

   int unsigned checks;
   int unsigned errors;
   logic [31:0] sb [$];

   right_shifter_unit #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .shamt     (shamt),
      .sra       (sra),
      .out_valid (out_valid),
      .shifted   (shifted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] s, input logic ar);
      logic [31:0] r;
      if (ar) r = $signed(x) >>> s;
      else    r = x >> s;
      return r;
   endfunction

   // Drives one valid operation on the falling edge and queues its expected result.
   task automatic drive_op(input logic [31:0] x, input logic [4:0] s, input logic ar, input logic [31:0] exp);
      @(negedge clk);
      in_valid = 1'b1;
      a        = x;
      shamt    = s;
      sra      = ar;
      sb.push_back(exp);
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      rst_n = 1'b1; in_valid = 1'b0; a = '0; shamt = '0; sra = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (shifted !== 32'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: shifted=%h out_valid=%b, required 00000000/0", shifted, out_valid);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (shifted !== 32'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: shifted=%h out_valid=%b, required 00000000/0", shifted, out_valid);
      end
   endtask

   task automatic test_logical_sweep();
      logic [31:0] exp;
      for (int s = 0; s < 32; s++) begin
         drive_op(32'h8000_0000, 5'(s), 1'b0, 32'h8000_0000 >> s);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL srl_sweep shamt=%0d: shifted=%h out_valid=%b, required %h/1", s, shifted, out_valid, exp);
         end
      end
   endtask

   task automatic test_arith_sweep();
      logic [31:0] exp;
      for (int s = 0; s < 32; s++) begin
         drive_op(32'h8000_0000, 5'(s), 1'b1, ~(32'h7FFF_FFFF >> s));
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL sra_sweep shamt=%0d: shifted=%h out_valid=%b, required %h/1", s, shifted, out_valid, exp);
         end
      end
   endtask

   task automatic test_positive_sra();
      logic [31:0] exp;
      logic [31:0] va [4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      logic [4:0]  vs [4] = '{5'd4, 5'd4, 5'd0, 5'd0};
      logic        vr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ve [4] = '{32'h07FF_FFFF, 32'h07FF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      for (int i = 0; i < 4; i++) begin
         drive_op(va[i], vs[i], vr[i], ve[i]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL positive_sra_case%0d: shifted=%h out_valid=%b, required %h/1", i, shifted, out_valid, exp);
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] exp;
      drive_op(32'hF000_0000, 5'd4, 1'b1, 32'hFF00_0000);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || shifted !== exp) begin
         errors++;
         $display("FAIL hold_op: shifted=%h out_valid=%b, required %h/1", shifted, out_valid, exp);
      end
      @(negedge clk);
      in_valid = 1'b0; a = 32'h1234_5678; shamt = 5'd1; sra = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || shifted !== 32'hFF00_0000) begin
         errors++;
         $display("FAIL hold_idle: shifted=%h out_valid=%b, required ff000000/0", shifted, out_valid);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] exp;
      drive_op(32'hA5A5_0000, 5'd8, 1'b1, 32'hFFA5_A500);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || shifted !== exp) begin
         errors++;
         $display("FAIL pre_reset_op: shifted=%h out_valid=%b, required %h/1", shifted, out_valid, exp);
      end
      // Another operation is in flight when reset hits between edges.
      drive_op(32'h0F0F_0F0F, 5'd4, 1'b0, 32'h00F0_F0F0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (shifted !== 32'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_immediate: shifted=%h out_valid=%b, required 00000000/0", shifted, out_valid);
      end
      sb.delete();
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (shifted !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: shifted=%h out_valid=%b, required 00000000/0", shifted, out_valid);
         end
      end
      drive_op(32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || shifted !== exp) begin
         errors++;
         $display("FAIL post_reset_op: shifted=%h out_valid=%b, required %h/1", shifted, out_valid, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x;
      logic [4:0]  s;
      logic        ar;
      logic [31:0] exp;
      for (int i = 0; i < 1000; i++) begin
         x  = $urandom;
         s  = 5'($urandom_range(31, 0));
         ar = 1'($urandom_range(1, 0));
         drive_op(x, s, ar, model(x, s, ar));
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL random_empty_scoreboard op=%0d: shifted=%h, required a queued result", i, shifted);
         end else begin
            exp = sb.pop_front();
            if (out_valid !== 1'b1 || shifted !== exp) begin
               errors++;
               $display("FAIL random op=%0d a=%h shamt=%0d sra=%b: shifted=%h out_valid=%b, required %h/1",
                        i, x, s, ar, shifted, out_valid, exp);
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_logical_sweep();
      test_arith_sweep();
      test_positive_sra();
      test_hold();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_right_shifter_unit
